spi_slave_sync: RTL and testbench

//  SPI responder running entirely in the system clock domain. It complements the spi_m initiator.

---
 rtl/spi_slave_sync_if.sv | 27 ++
 rtl/spi_slave_sync.sv | 187 ++++++++++++++++++
 tb/tb_spi_slave_sync.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_sync_if.sv
// spi_slave_sync_if: SPI pins plus the parallel rx/tx side of spi_slave_sync.
//   slave modport  : the responder (sclk/cs/sdi/tx_data/tx_valid in; sdo/rx_data/rx_valid/tx_ready/frame_err out)
//   master modport : the environment driving the SPI pins and the tx queue
interface spi_slave_sync_if #(
  parameter int unsigned DATA_W = 8
);
  logic              sclk;
  logic              cs;
  logic              sdi;
  logic              sdo;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              frame_err;

  modport slave (
    input  sclk, cs, sdi, tx_data, tx_valid,
    output sdo, rx_data, rx_valid, tx_ready, frame_err
  );

  modport master (
    output sclk, cs, sdi, tx_data, tx_valid,
    input  sdo, rx_data, rx_valid, tx_ready, frame_err
  );
endinterface

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: SPI responder clocked on the system clock. sclk/cs/sdi are
// oversampled through synchronizers; bits are captured LSB first on sclk falls.
// A cs-low frame carries DATA_W receive bits followed by DATA_W response bits.
// Ports:
//   clk, rst_n  system clock (>= 4x sclk), asynchronous active-low reset
//   bus         spi_slave_sync_if.slave (SPI pins, rx word/pulse, tx handshake, frame_err)
// Optional feature: define SPI_SLV_ECHO_EN to answer with the received word when
// no response is queued; otherwise the fallback response is all zeros.
module spi_slave_sync #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_slave_sync_if.slave bus
);

  localparam int unsigned CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, RX, TX, DONE} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, sdi_sync_q, fill_q;
  logic                   sclk_d1_q, cs_d1_q;
  logic                   s_sclk, s_cs, s_sdi, fall_c, cs_rise_c;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-2:0]  rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]  tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]  rx_data_q, rx_data_d;
  logic [DATA_W-1:0]  hold_q, hold_d;
  logic               sdo_q, sdo_d;
  logic               rx_done_q, rx_done_d;
  logic               rx_valid_q;
  logic               tx_ready_q, tx_ready_d;
  logic               frame_err_q, frame_err_d;
  logic               armed_q, armed_d;
  logic [DATA_W-1:0]  rx_word_c, fallback_c, resp_c;

  assign s_sclk    = sclk_sync_q[SYNC_STAGES-1];
  assign s_cs      = cs_sync_q[SYNC_STAGES-1];
  assign s_sdi     = sdi_sync_q[SYNC_STAGES-1];
  assign fall_c    = sclk_d1_q & ~s_sclk;
  assign cs_rise_c = ~cs_d1_q & s_cs;

  // Word completed by the current fall (bit DATA_W-1 enters at the MSB).
  assign rx_word_c = {s_sdi, rx_shift_q};

`ifdef SPI_SLV_ECHO_EN
  assign fallback_c = rx_word_c;
`else
  assign fallback_c = '0;
`endif

  // tx_ready_q low means the holding register is full.
  assign resp_c = tx_ready_q ? fallback_c : hold_q;

  assign bus.sdo       = sdo_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.tx_ready  = tx_ready_q;
  assign bus.frame_err = frame_err_q;

  // Synchronizers reset to the idle bus; fill_q marks when s_* hold real samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      sdi_sync_q  <= '0;
      fill_q      <= '0;
      sclk_d1_q   <= 1'b0;
      cs_d1_q     <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], bus.sdi};
      fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      sclk_d1_q   <= s_sclk;
      cs_d1_q     <= s_cs;
    end
  end

  // Frame FSM, holding register and output next-state logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    hold_d      = hold_q;
    sdo_d       = sdo_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;
    tx_ready_d  = tx_ready_q;
    // A cs already low at reset release must be seen high before a frame may start.
    armed_d     = armed_q | (fill_q[SYNC_STAGES-1] & s_cs);

    if (bus.tx_valid && tx_ready_q) begin
      hold_d     = bus.tx_data;
      tx_ready_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        sdo_d = 1'b0;
        cnt_d = '0;
        if (armed_q && !s_cs) state_d = RX;
      end
      RX: begin
        if (cs_rise_c) begin
          state_d     = IDLE;
          sdo_d       = 1'b0;
          cnt_d       = '0;
          frame_err_d = 1'b1;
        end else if (fall_c && !s_cs) begin
          rx_shift_d = rx_word_c[DATA_W-1:1];
          cnt_d      = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            rx_data_d  = rx_word_c;
            rx_done_d  = 1'b1;
            tx_shift_d = resp_c;
            sdo_d      = resp_c[0];
            cnt_d      = CNT_W'(1);
            state_d    = TX;
            if (!tx_ready_q) tx_ready_d = 1'b1;
          end
        end
      end
      TX: begin
        if (cs_rise_c) begin
          state_d     = IDLE;
          sdo_d       = 1'b0;
          cnt_d       = '0;
          frame_err_d = 1'b1;
        end else if (fall_c && !s_cs) begin
          sdo_d = tx_shift_q[cnt_q];
          if (cnt_q == LAST_BIT) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (s_cs) begin
          state_d = IDLE;
          sdo_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; rx_valid trails rx_data by one clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      hold_q      <= '0;
      sdo_q       <= 1'b0;
      rx_done_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      tx_ready_q  <= 1'b1;
      frame_err_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      hold_q      <= hold_d;
      sdo_q       <= sdo_d;
      rx_done_q   <= rx_done_d;
      rx_valid_q  <= rx_done_q;
      tx_ready_q  <= tx_ready_d;
      frame_err_q <= frame_err_d;
      armed_q     <= armed_d;
    end
  end

endmodule

// File: tb/tb_spi_slave_sync.sv
// tb_spi_slave_sync: directed frames against spi_slave_sync with a scoreboard.
// Stimulus pushes expected rx words and sdo responses into queues; monitors pop
// and compare whenever the DUT presents rx_valid or a completed response phase.
module tb_spi_slave_sync;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned HALF   = 4;  // clk cycles per sclk half period
`ifdef SPI_SLV_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_slave_sync_if #(.DATA_W(DATA_W)) bus ();

  spi_slave_sync #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int ferr_cnt = 0;
  logic [7:0] rx_exp_q[$];
  logic [7:0] resp_exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] fallback(input logic [7:0] w);
    return ECHO ? w : 8'h00;
  endfunction

  // rx monitor: every rx_valid must match the next expected word and be a 1-clk pulse.
  logic prev_rxv = 1'b0;
  always @(negedge clk) begin
    if (rst_n && bus.rx_valid) begin
      if (prev_rxv) begin
        n_chk++;
        $display("FAIL rx_valid_width: rx_valid high on consecutive clks");
      end else if (rx_exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL rx_valid_unexpected: rx_data=0x%0h with no word expected", bus.rx_data);
      end else begin
        chk("rx_data", 32'(bus.rx_data), 32'(rx_exp_q.pop_front()));
      end
    end
    prev_rxv = bus.rx_valid;
    if (bus.frame_err) ferr_cnt++;
  end

  // sdo monitor: initiator samples on sclk rise; rises 8..15 carry the response.
  int rises = 0;
  logic [7:0] resp_word = 8'h00;
  always @(posedge bus.sclk or posedge bus.cs) begin
    if (bus.cs) begin
      rises = 0;
    end else begin
      if (rises >= 8) resp_word[3'(rises - 8)] = bus.sdo;
      rises++;
      if (rises == 16) begin
        if (resp_exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL sdo_unexpected: got 0x%0h with no response expected", resp_word);
        end else begin
          chk("sdo_resp", 32'(resp_word), 32'(resp_exp_q.pop_front()));
        end
      end
    end
  end

  // One cs-low frame of ncyc sclk cycles; optional tx pulse aligned with the RX->TX transition.
  task automatic frame(input logic [7:0] d, input int ncyc, input bit pulse_tx, input logic [7:0] txw);
    bus.cs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < ncyc; k++) begin
      bus.sclk = 1'b1;
      bus.sdi  = (k < 8) ? d[3'(k)] : 1'b0;
      repeat (HALF) @(negedge clk);
      bus.sclk = 1'b0;
      for (int j = 0; j < int'(HALF); j++) begin
        @(negedge clk);
        if (pulse_tx && k == 7) begin
          if (j == 1) begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = txw;
          end else if (j == 2) begin
            bus.tx_valid = 1'b0;
          end
        end
      end
    end
    bus.cs = 1'b1;
    repeat (3 * HALF) @(negedge clk);
  endtask

  task automatic queue_tx(input logic [7:0] w);
    chk("tx_ready_before_load", 32'(bus.tx_ready), 32'd1);
    bus.tx_valid = 1'b1;
    bus.tx_data  = w;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    chk("tx_ready_after_load", 32'(bus.tx_ready), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int f0;
    rst_n = 1'b0;
    bus.cs = 1'b1; bus.sclk = 1'b0; bus.sdi = 1'b0;
    bus.tx_valid = 1'b0; bus.tx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_sdo", 32'(bus.sdo), 32'd0);
    chk("rst_rx_data", 32'(bus.rx_data), 32'd0);
    chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: plain frame, nothing queued
    rx_exp_q.push_back(8'hA5); resp_exp_q.push_back(fallback(8'hA5));
    frame(8'hA5, 16, 1'b0, 8'h00);
    chk("t1_tx_ready", 32'(bus.tx_ready), 32'd1);

    // 2: queued response
    queue_tx(8'h3C);
    rx_exp_q.push_back(8'h81); resp_exp_q.push_back(8'h3C);
    frame(8'h81, 16, 1'b0, 8'h00);
    chk("t2_tx_ready", 32'(bus.tx_ready), 32'd1);
    chk("t2_rx_data_held", 32'(bus.rx_data), 32'h81);

    // 3: abort after 4 RX bits, then a good frame
    f0 = ferr_cnt;
    frame(8'h0F, 4, 1'b0, 8'h00);
    chk("t3_frame_err", 32'(ferr_cnt - f0), 32'd1);
    chk("t3_sdo", 32'(bus.sdo), 32'd0);
    chk("t3_rx_data_kept", 32'(bus.rx_data), 32'h81);
    rx_exp_q.push_back(8'h5A); resp_exp_q.push_back(fallback(8'h5A));
    frame(8'h5A, 16, 1'b0, 8'h00);

    // 4: abort after 3 TX bits with 0xF0 queued; the word is lost
    queue_tx(8'hF0);
    rx_exp_q.push_back(8'h33);
    f0 = ferr_cnt;
    frame(8'h33, 11, 1'b0, 8'h00);
    chk("t4_frame_err", 32'(ferr_cnt - f0), 32'd1);
    chk("t4_sdo", 32'(bus.sdo), 32'd0);
    chk("t4_tx_ready", 32'(bus.tx_ready), 32'd1);
    rx_exp_q.push_back(8'hC3); resp_exp_q.push_back(fallback(8'hC3));
    frame(8'hC3, 16, 1'b0, 8'h00);

    // 5: reset mid-RX with cs held low through release
    queue_tx(8'h77);
    f0 = ferr_cnt;
    bus.cs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      bus.sclk = 1'b1; bus.sdi = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.sclk = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("t5_rst_sdo", 32'(bus.sdo), 32'd0);
    chk("t5_rst_rx_data", 32'(bus.rx_data), 32'd0);
    chk("t5_rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("t5_rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    chk("t5_rst_frame_err", 32'(bus.frame_err), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.sclk = 1'b1; bus.sdi = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.sclk = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    chk("t5_sdo_idle", 32'(bus.sdo), 32'd0);
    bus.cs = 1'b1;
    repeat (3 * HALF) @(negedge clk);
    chk("t5_no_frame_err", 32'(ferr_cnt - f0), 32'd0);
    chk("t5_rx_data", 32'(bus.rx_data), 32'd0);

    // 6: back-to-back frames, tx pulse on the second RX->TX transition
    rx_exp_q.push_back(8'h00); resp_exp_q.push_back(fallback(8'h00));
    frame(8'h00, 16, 1'b0, 8'h00);
    rx_exp_q.push_back(8'hFF); resp_exp_q.push_back(fallback(8'hFF));
    frame(8'hFF, 16, 1'b1, 8'h6D);
    chk("t6_tx_held", 32'(bus.tx_ready), 32'd0);
    rx_exp_q.push_back(8'h12); resp_exp_q.push_back(8'h6D);
    frame(8'h12, 16, 1'b0, 8'h00);
    chk("t6_tx_ready", 32'(bus.tx_ready), 32'd1);

    repeat (20) @(negedge clk);
    chk("rx_words_outstanding", 32'(rx_exp_q.size()), 32'd0);
    chk("resp_words_outstanding", 32'(resp_exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
